ifu_fetch_ctrl: RTL and testbench

//  Parametrised next-generation instruction fetch unit: owns the PC, does a same-cycle lookup in an external I$,

---
 rtl/ifu_fetch_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_ctrl.sv
// Instruction fetch unit: PC ownership, same-cycle I$ lookup, miss/refill FSM, next-PC prediction and IFIFO.
// Optional static BTFN/JAL prediction is enabled by defining IFU_STATIC_PRED_EN.
module ifu_fetch_ctrl #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    BLOCK_SIZE  = 64,
    parameter int                    IFIFO_DEPTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                                clk,
    input  logic                                rst_aL,
    input  logic [ADDR_WIDTH-1:0]               recovery_PC,
    input  logic                                recovery_PC_valid,
    input  logic                                backend_stall,
    output logic [ADDR_WIDTH-1:0]               icache_rd_addr,
    input  logic                                icache_hit,
    input  logic [BLOCK_SIZE-1:0]               icache_rd_block,
    output logic                                icache_we,
    output logic [ADDR_WIDTH-1:0]               icache_waddr,
    output logic [BLOCK_SIZE-1:0]               icache_wdata,
    output logic                                dram_req_valid,
    input  logic                                dram_req_ready,
    output logic [ADDR_WIDTH-1:0]               dram_req_addr,
    input  logic [BLOCK_SIZE-1:0]               dram_response,
    input  logic                                dram_response_valid,
    input  logic                                dispatch_ready,
    output logic                                instr_valid,
    output logic [INSTR_WIDTH+2*ADDR_WIDTH+1:0] instr_data
);
    localparam int WORDS   = BLOCK_SIZE / INSTR_WIDTH;
    localparam int IDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int OFF_W   = $clog2(BLOCK_SIZE / 8);
    localparam int PTR_W   = $clog2(IFIFO_DEPTH);
    localparam int ENTRY_W = INSTR_WIDTH + 2 * ADDR_WIDTH + 2;

    typedef enum logic [1:0] {
        S_FETCH,
        S_MISS_REQ,
        S_MISS_WAIT,
        S_REFILL
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_pc;
    logic [ADDR_WIDTH-1:0]   r_miss_addr;
    logic [BLOCK_SIZE-1:0]   r_refill_data;
    logic [ENTRY_W-1:0]      r_mem [IFIFO_DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [PTR_W:0]          r_count;

    logic [INSTR_WIDTH-1:0]  w_words [WORDS];
    logic [IDX_W-1:0]        w_word_idx;
    logic [INSTR_WIDTH-1:0]  w_instr;
    logic                    w_is_b;
    logic                    w_is_jal;
    logic [ADDR_WIDTH-1:0]   w_imm_b;
    logic [ADDR_WIDTH-1:0]   w_imm_j;
    logic [ADDR_WIDTH-1:0]   w_pc_plus4;
    logic [ADDR_WIDTH-1:0]   w_target;
    logic                    w_pred_taken;
    logic [ADDR_WIDTH-1:0]   w_next_pc;
    logic [ENTRY_W-1:0]      w_entry;
    logic                    w_redirect;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_pop;
    logic                    w_enq;
    logic                    w_miss;

    // Word 0 of the block sits in the least-significant bits.
    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_word
            assign w_words[gi] = icache_rd_block[gi*INSTR_WIDTH +: INSTR_WIDTH];
        end
        if (WORDS > 1) begin : g_idx
            assign w_word_idx = r_pc[IDX_W+1:2];
        end else begin : g_idx_one
            assign w_word_idx = '0;
        end
    endgenerate

    assign w_instr    = w_words[w_word_idx];
    assign w_is_b     = (w_instr[6:0] == 7'b1100011);
    assign w_is_jal   = (w_instr[6:0] == 7'b1101111);
    assign w_imm_b    = {{(ADDR_WIDTH-12){w_instr[31]}}, w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
    assign w_imm_j    = {{(ADDR_WIDTH-20){w_instr[31]}}, w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};
    assign w_pc_plus4 = r_pc + ADDR_WIDTH'(4);
    assign w_target   = w_is_b   ? (r_pc + w_imm_b) :
                        w_is_jal ? (r_pc + w_imm_j) : w_pc_plus4;

`ifdef IFU_STATIC_PRED_EN
    // Backward-taken/forward-not-taken: a negative B-type offset has its sign bit in instr[31].
    assign w_pred_taken = (w_is_b & w_instr[31]) | w_is_jal;
`else
    assign w_pred_taken = 1'b0;
`endif

    assign w_next_pc = w_pred_taken ? w_target : w_pc_plus4;
    assign w_entry   = {w_instr, r_pc, w_is_b, w_pred_taken, w_target};

    assign w_redirect = recovery_PC_valid;
    assign w_full     = (r_count == (PTR_W+1)'(IFIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_pop      = dispatch_ready & ~w_empty & ~w_redirect;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_enq      = (r_state == S_FETCH) & icache_hit & ~backend_stall & ~w_redirect
                        & (~w_full | w_pop);
    assign w_miss     = (r_state == S_FETCH) & ~icache_hit & ~w_redirect;

    assign icache_rd_addr = r_pc;
    assign instr_valid    = ~w_empty;
    assign instr_data     = w_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        dram_req_valid = 1'b0;
        dram_req_addr  = '0;
        icache_we      = 1'b0;
        icache_waddr   = '0;
        icache_wdata   = '0;
        unique case (r_state)
            S_FETCH: begin
                if (w_miss) w_state_next = S_MISS_REQ;
            end
            S_MISS_REQ: begin
                dram_req_valid = 1'b1;
                dram_req_addr  = r_miss_addr;
                if (w_redirect)          w_state_next = S_FETCH;
                else if (dram_req_ready) w_state_next = S_MISS_WAIT;
            end
            // A redirect here only moves the PC; the outstanding refill still completes.
            S_MISS_WAIT: begin
                if (dram_response_valid) w_state_next = S_REFILL;
            end
            S_REFILL: begin
                icache_we    = 1'b1;
                icache_waddr = r_miss_addr;
                icache_wdata = r_refill_data;
                w_state_next = S_FETCH;
            end
            default: w_state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            r_pc          <= RESET_PC;
            r_miss_addr   <= '0;
            r_refill_data <= '0;
        end else begin
            if (w_redirect)  r_pc <= recovery_PC;
            else if (w_enq)  r_pc <= w_next_pc;
            if (w_miss)      r_miss_addr <= {r_pc[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            if ((r_state == S_MISS_WAIT) && dram_response_valid) r_refill_data <= dram_response;
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) r_mem[r_wr_ptr] <= w_entry;
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_redirect) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            unique case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl with an I$/DRAM model and a scoreboard monitor on IFIFO pops.
module tb_ifu_fetch_ctrl;
    localparam int AW = 32;
    localparam int IW = 32;
    localparam int BS = 64;
    localparam int EW = IW + 2 * AW + 2;

    logic          clk = 1'b0;
    logic          rst_aL;
    logic [AW-1:0] recovery_PC;
    logic          recovery_PC_valid;
    logic          backend_stall;
    logic [AW-1:0] icache_rd_addr;
    logic          icache_hit;
    logic [BS-1:0] icache_rd_block;
    logic          icache_we;
    logic [AW-1:0] icache_waddr;
    logic [BS-1:0] icache_wdata;
    logic          dram_req_valid;
    logic          dram_req_ready;
    logic [AW-1:0] dram_req_addr;
    logic [BS-1:0] dram_response;
    logic          dram_response_valid;
    logic          dispatch_ready;
    logic          instr_valid;
    logic [EW-1:0] instr_data;

    int            checks = 0;
    int            errors = 0;
    logic [EW-1:0] sb_q [$];
    logic          cv [256];
    logic          branch_en = 1'b0;
    int            we_count = 0;
    logic [AW-1:0] last_waddr = '0;
    logic [AW-1:0] last_req_addr = '0;
    int            resp_cnt = 0;
    logic [AW-1:0] resp_addr = '0;

    always #5 clk = ~clk;

    ifu_fetch_ctrl #(
        .ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .BLOCK_SIZE(BS), .IFIFO_DEPTH(8), .RESET_PC('0)
    ) dut (
        .clk(clk), .rst_aL(rst_aL),
        .recovery_PC(recovery_PC), .recovery_PC_valid(recovery_PC_valid),
        .backend_stall(backend_stall),
        .icache_rd_addr(icache_rd_addr), .icache_hit(icache_hit), .icache_rd_block(icache_rd_block),
        .icache_we(icache_we), .icache_waddr(icache_waddr), .icache_wdata(icache_wdata),
        .dram_req_valid(dram_req_valid), .dram_req_ready(dram_req_ready), .dram_req_addr(dram_req_addr),
        .dram_response(dram_response), .dram_response_valid(dram_response_valid),
        .dispatch_ready(dispatch_ready), .instr_valid(instr_valid), .instr_data(instr_data)
    );

    // beq x0,x0,-16 lives at 0x20 only once branch_en is set; every other word is an addi.
    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic ben);
        if (ben && a == 32'h20) return 32'hFE0008E3;
        return {a[24:0], 7'b0010011};
    endfunction

    function automatic logic [63:0] mem_block(input logic [31:0] a, input logic ben);
        logic [31:0] b;
        b = {a[31:3], 3'b000};
        return {mem_word(b + 32'd4, ben), mem_word(b, ben)};
    endfunction

    assign icache_hit      = cv[icache_rd_addr[10:3]];
    assign icache_rd_block = mem_block(icache_rd_addr, branch_en);

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_entry(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [31:0] pc);
        sb_q.push_back({mem_word(pc, 1'b0), pc, 1'b0, 1'b0, pc + 32'd4});
    endtask

    task automatic redirect(input logic [31:0] pc);
        recovery_PC       = pc;
        recovery_PC_valid = 1'b1;
        tick();
        recovery_PC_valid = 1'b0;
    endtask

    // Scoreboard monitor: a pop happens at the next edge whenever this condition holds.
    initial begin
        logic [EW-1:0] exp;
        forever begin
            @(negedge clk);
            if (rst_aL && instr_valid && dispatch_ready && !recovery_PC_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ififo_unexpected actual=%h required=none", instr_data);
                end else begin
                    exp = sb_q.pop_front();
                    $display("POP pc=%h instr=%h br=%0d pred=%0d tgt=%h",
                             instr_data[AW*2+1:AW+2], instr_data[EW-1:EW-IW],
                             instr_data[AW+1], instr_data[AW], instr_data[AW-1:0]);
                    check_entry("ififo_entry", instr_data, exp);
                end
            end
        end
    end

    // I$ write port model.
    initial begin
        forever begin
            @(negedge clk);
            if (icache_we) begin
                we_count++;
                last_waddr = icache_waddr;
                $display("REFILL waddr=%h", icache_waddr);
                checks++;
                if (icache_wdata !== mem_block(icache_waddr, branch_en)) begin
                    errors++;
                    $display("FAIL refill_wdata actual=%h required=%h", icache_wdata,
                             mem_block(icache_waddr, branch_en));
                end
                cv[icache_waddr[10:3]] = 1'b1;
            end
        end
    end

    // DRAM model: single-cycle response strobe three cycles after the accepting edge.
    initial begin
        dram_response       = '0;
        dram_response_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_aL && dram_req_valid && dram_req_ready) begin
                resp_cnt      = 3;
                resp_addr     = dram_req_addr;
                last_req_addr = dram_req_addr;
                $display("DRAM_REQ addr=%h", dram_req_addr);
            end
            @(posedge clk);
            #1;
            dram_response_valid = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    dram_response_valid = 1'b1;
                    dram_response       = mem_block(resp_addr, branch_en);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] npc;
    logic        pred;

    initial begin
        for (int i = 0; i < 256; i++) cv[i] = 1'b1;
        cv[8]  = 1'b0;   // 0x40
        cv[16] = 1'b0;   // 0x80
        cv[24] = 1'b0;   // 0xC0
        rst_aL            = 1'b0;
        recovery_PC       = '0;
        recovery_PC_valid = 1'b0;
        backend_stall     = 1'b0;
        dram_req_ready    = 1'b1;
        dispatch_ready    = 1'b1;

        // Reset state
        @(negedge clk);
        check32("rst_rd_addr", icache_rd_addr, 32'h0);
        check32("rst_instr_valid", 32'(instr_valid), 32'd0);
        check32("rst_dram_req_valid", 32'(dram_req_valid), 32'd0);
        check32("rst_icache_we", 32'(icache_we), 32'd0);
        check_entry("rst_instr_data", instr_data, '0);

        // Sequential hits from RESET_PC
        for (int i = 0; i < 6; i++) push_seq(32'(i * 4));
        repeat (2) @(posedge clk);
        #1 rst_aL = 1'b1;
        @(negedge clk);
        check32("seq_valid_before_first_edge", 32'(instr_valid), 32'd0);
        tick();
        @(negedge clk);
        check32("seq_valid_after_first_edge", 32'(instr_valid), 32'd1);
        repeat (5) tick();
        backend_stall = 1'b1;
        repeat (3) tick();
        check32("seq_sb_empty", 32'(sb_q.size()), 32'd0);
        check32("seq_pc_held", icache_rd_addr, 32'h18);

        // IFIFO full, then simultaneous pop+enqueue while full
        dispatch_ready = 1'b0;
        backend_stall  = 1'b0;
        for (int i = 0; i < 8; i++) push_seq(32'h18 + 32'(i * 4));
        repeat (10) tick();
        check32("full_pc_frozen", icache_rd_addr, 32'h38);
        check32("full_valid", 32'(instr_valid), 32'd1);
        push_seq(32'h38);
        dispatch_ready = 1'b1;
        tick();
        dispatch_ready = 1'b0;
        check32("full_pop_enq_pc", icache_rd_addr, 32'h3C);
        tick();
        check32("full_still_full_pc", icache_rd_addr, 32'h3C);
        backend_stall  = 1'b1;
        dispatch_ready = 1'b1;
        repeat (10) tick();
        check32("full_sb_empty", 32'(sb_q.size()), 32'd0);

        // Miss at 0x40 with a three-cycle DRAM
        backend_stall = 1'b0;
        push_seq(32'h3C); push_seq(32'h40); push_seq(32'h44); push_seq(32'h48);
        repeat (10) tick();
        backend_stall = 1'b1;
        repeat (4) tick();
        check32("miss_sb_empty", 32'(sb_q.size()), 32'd0);
        check32("miss_pc", icache_rd_addr, 32'h4C);
        check32("miss_we_count", 32'(we_count), 32'd1);
        check32("miss_waddr", last_waddr, 32'h40);
        check32("miss_req_addr", last_req_addr, 32'h40);

        // dram_req_ready low for five cycles on a miss at 0xC0
        backend_stall  = 1'b0;
        dram_req_ready = 1'b0;
        redirect(32'hC0);
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check32("hold_req_valid", 32'(dram_req_valid), 32'd1);
            check32("hold_req_addr", dram_req_addr, 32'hC0);
            tick();
        end
        dram_req_ready = 1'b1;
        push_seq(32'hC0); push_seq(32'hC4);
        repeat (7) tick();
        backend_stall = 1'b1;
        repeat (4) tick();
        check32("hold_sb_empty", 32'(sb_q.size()), 32'd0);
        check32("hold_pc", icache_rd_addr, 32'hC8);
        check32("hold_waddr", last_waddr, 32'hC0);

        // Redirect to 0x100 while waiting on the 0x80 refill
        backend_stall  = 1'b0;
        dispatch_ready = 1'b0;
        redirect(32'h78);
        repeat (4) tick();
        check32("rdw_fifo_filled", 32'(instr_valid), 32'd1);
        redirect(32'h100);
        check32("rdw_flushed", 32'(instr_valid), 32'd0);
        check32("rdw_pc", icache_rd_addr, 32'h100);
        check32("rdw_no_new_req", 32'(dram_req_valid), 32'd0);
        push_seq(32'h100); push_seq(32'h104);
        dispatch_ready = 1'b1;
        repeat (5) tick();
        backend_stall = 1'b1;
        repeat (4) tick();
        check32("rdw_sb_empty", 32'(sb_q.size()), 32'd0);
        check32("rdw_pc_after", icache_rd_addr, 32'h108);
        check32("rdw_we_count", 32'(we_count), 32'd3);
        check32("rdw_waddr_old_miss", last_waddr, 32'h80);

        // BEQ at 0x20 with imm=-16
`ifdef IFU_STATIC_PRED_EN
        pred = 1'b1;
        npc  = 32'h10;
`else
        pred = 1'b0;
        npc  = 32'h24;
`endif
        branch_en     = 1'b1;
        backend_stall = 1'b0;
        sb_q.push_back({32'hFE0008E3, 32'h20, 1'b1, pred, 32'h10});
        push_seq(npc);
        redirect(32'h20);
        tick();
        check32("br_next_pc", icache_rd_addr, npc);
        tick();
        backend_stall = 1'b1;
        check32("br_pc_after", icache_rd_addr, npc + 32'd4);
        repeat (4) tick();
        check32("br_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
